// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared arithmetic constants for the multiplier datapath
package mul_pkg;

  // Default operand/result width of the carry-save resolve stage.
  localparam int CSA_RESOLVE_WIDTH = 64;

  // Cycles from the accepting edge to a valid result, with no backpressure.
  localparam int CSA_RESOLVE_LAT = 2;

endpackage

// File: rtl/cpa_slice.sv
// rtl/cpa_slice.sv - combinational carry-propagate adder slice with carry in/out
module cpa_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] total;

  // Widen by one bit so the carry out falls into the top bit.
  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s     = total[W-1:0];
  assign cout  = total[W];

endmodule

// File: rtl/csa_resolve_stage.sv
// rtl/csa_resolve_stage.sv - two-stage carry-save to binary resolver (optional CSA_RESOLVE_COUT_EN adds cout)
module csa_resolve_stage
  import mul_pkg::*;
#(
  parameter int WIDTH = CSA_RESOLVE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef CSA_RESOLVE_COUT_EN
  ,
  output logic             cout
`endif
);

  localparam int HALF = WIDTH / 2;

  // The carry vector's bit i weighs 2^(i+1); shifting at full width drops its MSB.
  logic [WIDTH-1:0] carry_sh;
  assign carry_sh = carry_in << 1;

  // Stage 1 state: low half result, its carry out, and the raw high halves.
  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] lo_q,       lo_d;
  logic            c_q,        c_d;
  logic [HALF-1:0] a_hi_q,     a_hi_d;
  logic [HALF-1:0] b_hi_q,     b_hi_d;

  // Stage 2 state: the full resolved value.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;

  logic [HALF-1:0] lo_sum;
  logic            lo_cout;
  logic [HALF-1:0] hi_sum;
  logic            hi_cout;

  logic s2_can_load;
  logic s1_advance;
  logic accept;

  cpa_slice #(.W(HALF)) u_lo_add (
    .a    (sum_in[HALF-1:0]),
    .b    (carry_sh[HALF-1:0]),
    .cin  (1'b0),
    .s    (lo_sum),
    .cout (lo_cout)
  );

  cpa_slice #(.W(HALF)) u_hi_add (
    .a    (a_hi_q),
    .b    (b_hi_q),
    .cin  (c_q),
    .s    (hi_sum),
    .cout (hi_cout)
  );

  assign s2_can_load = !out_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign s1_advance  = s1_valid_q && s2_can_load;
  assign accept      = in_valid && in_ready;

  // Stage 1 loads only on a handshake; otherwise it holds, emptying only when it advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    lo_d       = lo_q;
    c_d        = c_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      lo_d       = lo_sum;
      c_d        = lo_cout;
      a_hi_d     = sum_in[WIDTH-1:HALF];
      b_hi_d     = carry_sh[WIDTH-1:HALF];
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 takes stage 1 whenever it is free or draining this cycle, else holds its result.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (s1_advance) begin
      out_valid_d = 1'b1;
      result_d    = {hi_sum, lo_q};
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_q        <= '0;
      c_q         <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      lo_q        <= lo_d;
      c_q         <= c_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

`ifdef CSA_RESOLVE_COUT_EN
  logic cout_q, cout_d;

  // The final carry out travels with the result it belongs to.
  always_comb begin
    cout_d = cout_q;
    if (s1_advance) begin
      cout_d = hi_cout;
    end
  end

  // Carry-out register, cleared with the rest of stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout_q <= 1'b0;
    end else begin
      cout_q <= cout_d;
    end
  end

  assign cout = cout_q;
`else
  logic unused_hi_cout;
  assign unused_hi_cout = hi_cout;
`endif

endmodule

// File: tb/tb_csa_resolve_stage.sv
// tb/tb_csa_resolve_stage.sv - directed self-checking bench for csa_resolve_stage (honours CSA_RESOLVE_COUT_EN)
module tb_csa_resolve_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sum_in;
  logic [63:0] carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
`ifdef CSA_RESOLVE_COUT_EN
  logic        cout;
`endif

  int checks;
  int errors;

  csa_resolve_stage #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef CSA_RESOLVE_COUT_EN
    ,
    .cout      (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one pair into an idle pipeline and check it appears on the second edge.
  task automatic run_single(input string tag, input logic [63:0] s, input logic [63:0] c,
                            input logic [63:0] exp, input logic exp_cout, input logic chk_cout);
    sum_in    = s;
    carry_in  = c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sum_in   = '0;
    carry_in = '0;
    #1;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #2;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, result, exp);
`ifdef CSA_RESOLVE_COUT_EN
    if (chk_cout) check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
`else
    if (chk_cout && exp_cout) begin end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int in_idx;
    int exp_val;
    int nout;
    int first;
    int last;
    int stalls;
    int stale;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    carry_in  = '0;

    // Reset state.
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors.
    run_single("basic",  64'd5, 64'd3, 64'h0B, 1'b0, 1'b1);
    run_single("locross", 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000001, 1'b0, 1'b1);
    run_single("wrap",   64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'h00000000_00000001, 1'b1, 1'b1);
    run_single("mix",    64'h01234567_89ABCDEF, 64'h11111111_11111111, 64'h23456789_ABCDF011, 1'b0, 1'b1);
    run_single("nolo",   64'h00000000_7FFFFFFF, 64'h00000000_40000000, 64'h00000000_FFFFFFFF, 1'b0, 1'b1);
    run_single("msbdrop", 64'h0, 64'h80000000_00000000, 64'h0, 1'b0, 1'b0);

    // Backpressure and ordering: 8 values, out_ready low for the first 4 cycles.
    in_idx  = 1;
    exp_val = 1;
    nout    = 0;
    for (int c = 0; c < 60 && nout < 8; c++) begin
      out_ready = (c >= 4);
      if (in_idx <= 8) begin
        in_valid = 1'b1;
        sum_in   = 64'(in_idx);
        carry_in = '0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2 || c == 3) begin
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_result", result, 64'd1);
      end
      if (out_valid && out_ready) begin
        check("bp_order", result, 64'(exp_val));
        exp_val++;
        nout++;
      end
      if (in_valid && in_ready) in_idx++;
      @(posedge clk);
      #1;
    end
    check("bp_count", 64'(nout), 64'd8);
    in_valid = 1'b0;
    stale    = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid) stale++;
      @(posedge clk);
      #1;
    end
    check("bp_no_dup", 64'(stale), 64'd0);

    // Throughput: 16 back-to-back inputs, outputs on cycles 2..17.
    out_ready = 1'b1;
    first     = -1;
    last      = -1;
    nout      = 0;
    stalls    = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        sum_in   = 64'(100 + c);
        carry_in = 64'(c);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) stalls++;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        check("tp_result", result, 64'(100 + 3 * nout));
        nout++;
      end
      @(posedge clk);
      #1;
    end
    check("tp_first", 64'(first), 64'd2);
    check("tp_last", 64'(last), 64'd17);
    check("tp_count", 64'(nout), 64'd16);
    check("tp_stalls", 64'(stalls), 64'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_in    = 64'd7;
    carry_in  = '0;
    @(posedge clk);
    #1;
    sum_in = 64'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("mr_pre_valid", 64'(out_valid), 64'd1);
    check("mr_pre_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_async_valid", 64'(out_valid), 64'd0);
    check("mr_async_result", result, 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #2;
      if (out_valid) stale++;
    end
    check("mr_no_stale", 64'(stale), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_resolve_stage.md
CSA_RESOLVE_STAGE -- requirements
Module: csa_resolve_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand and result width; WIDTH SHALL be even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the sum/carry pair on the input is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage accepts the input pair this cycle.
REQ-006 SHALL have port sum_in, input, WIDTH bits: the carry-save sum vector.
REQ-007 SHALL have port carry_in, input, WIDTH bits: the carry-save carry vector, unshifted, where bit i has weight 2^(i+1).
REQ-008 SHALL have port out_valid, output, 1 bit: result holds a valid value.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-010 SHALL have port result, output, WIDTH bits: the resolved binary value.

Function
REQ-011 SHALL compute result = (sum_in + (carry_in << 1)) mod 2^WIDTH; carry_in[WIDTH-1] is discarded.
REQ-012 SHALL be a 2-stage pipeline with fixed latency 2 cycles from the accepting edge to out_valid=1, given no backpressure.
- Stage 1: adds the low WIDTH/2 bits, registers the low result and the carry out, and registers the high operand halves.
- Stage 2: adds the high halves plus the registered carry, and registers the full result.
REQ-013 SHALL accept an input when in_valid && in_ready at the rising edge.
REQ-014 SHALL output a result when out_valid && out_ready at the rising edge.
REQ-015 SHALL drive in_ready = !s1_valid || s2_can_load, where s2_can_load = !out_valid || out_ready; in_ready SHALL be combinational and SHALL NOT depend on in_valid.
REQ-016 SHALL sustain one transfer per cycle when in_valid=1 and out_ready=1 continuously, with no bubbles.
REQ-017 SHALL hold result and out_valid stable while out_valid=1 and out_ready=0, and SHALL hold stage 1 contents while stage 2 is stalled.
REQ-018 SHALL, on a simultaneous output handshake and stage-1 advance in one cycle, load the new value into stage 2 with out_valid remaining 1 and no result lost or duplicated.
REQ-019 SHALL keep stage 1 registers unchanged when in_valid=0; s1_valid SHALL clear only when stage 1 advances into stage 2.
REQ-020 SHALL preserve the order of results exactly as inputs were accepted.

Reset
REQ-021 SHALL, while rst=1, force out_valid=0, s1_valid=0 and result=0 asynchronously, and set all data registers to 0.
REQ-022 SHALL drop any in-flight operands on reset mid-operation, produce no output for them, and drive in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, when macro CSA_RESOLVE_COUT_EN is defined, add output port cout (1 bit), registered alongside result.
- cout = bit WIDTH of (sum_in + (carry_in << 1)).
- cout resets to 0.
REQ-024 SHALL, when CSA_RESOLVE_COUT_EN is undefined, omit the cout port and its logic, with all other behaviour identical.

Structure
REQ-025 SHALL place the default WIDTH constant (64) and the latency constant CSA_RESOLVE_LAT=2 in the shared arithmetic package mul_pkg.
REQ-026 SHALL implement each half-width add with one sub-module cpa_slice: WIDTH/2-bit operands a and b, carry-in cin, sum out s, carry-out cout; combinational; instantiated twice.

Verification
REQ-027 SHALL cover at WIDTH=64: sum_in=5, carry_in=3, out_ready=1 -> result=11 (0x0B) two cycles after acceptance.
REQ-028 SHALL cover low-half carry crossing: sum_in=0x00000000_FFFFFFFF, carry_in=0x00000000_00000001 -> result=0x00000001_00000001.
REQ-029 SHALL cover wrap: sum_in=0xFFFFFFFF_FFFFFFFF, carry_in=0x1 -> result=0x00000000_00000001, and with CSA_RESOLVE_COUT_EN cout=1.
REQ-030 SHALL cover backpressure and order: stream 8 back-to-back inputs with values 1..8, hold out_ready=0 for 4 cycles -> in_ready=0 once both stages are full, result held stable, all 8 results delivered in order with none lost or duplicated.
REQ-031 SHALL cover throughput: continuous in_valid=1 and out_ready=1 over 16 inputs -> 16 outputs on 16 consecutive cycles starting at cycle 2.
REQ-032 SHALL cover reset mid-operation: assert rst while both stages are valid -> out_valid=0 immediately, no stale output after release, and in_ready=1.
